// File: rtl/bch_ibm_solver.sv
// Simplified inversionless Berlekamp-Massey key-equation solver: 2T syndromes in, error locator Lambda(x) out.
// Latency: T cycles from accept to out_valid (T+M when BCH_IBM_NORMALIZE_EN is defined, adding Lambda0=1 scaling).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and in_valid while busy is ignored.
module bch_ibm_solver #(
    parameter int         M         = 4,
    parameter int         T         = 2,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*T*M-1:0]           syndromes,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(T+1)*M-1:0]         lambda,
    output logic [$clog2(T+1)-1:0]     degree
);

    localparam int KW = $clog2(T + 2) + 1;
    localparam int RW = $clog2(T + 1);
    localparam int DW = $clog2(T + 1);
    localparam logic signed [KW-1:0] K_ONE = 1;

`ifdef BCH_IBM_NORMALIZE_EN
    localparam int NW = $clog2(M);
    typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

    state_t                   state;
    logic [2*T-1:0][M-1:0]    syn;      // syn[n] holds S_(n+1)
    logic [T:0][M-1:0]        lam;
    logic [T:0][M-1:0]        bb;
    logic [M-1:0]             gamma;
    logic signed [KW-1:0]     k;
    logic [RW-1:0]            r;

    logic [M-1:0]             delta;
    logic                     upd;
    logic [T:0][M-1:0]        lam_nxt;
    logic [T:0][M-1:0]        bb_nxt;

    // Shift-and-add GF(2^M) multiply, reducing by PRIM_POLY at each shift
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[M-2:0], 1'b0} ^ (aa[M-1] ? PRIM_POLY[M-1:0] : '0);
        end
        return p;
    endfunction

    assign lambda = lam;

    // Discrepancy: coefficient of x^(2r) in S(x)*Lambda(x); iteration index selects the syndrome window
    always_comb begin
        delta = '0;
        for (int j = 0; j < T; j++) begin
            if (r == RW'(j)) begin
                for (int i = 0; i <= T; i++) begin
                    if (i <= 2 * j) delta = delta ^ gf_mul(lam[i], syn[2*j-i]);
                end
            end
        end
    end

    // Next Lambda and B; B takes x*Lambda_old when the discrepancy is usable, otherwise shifts by x^2
    always_comb begin
        upd        = (delta != '0) && !k[KW-1];
        lam_nxt    = '0;
        bb_nxt     = '0;
        lam_nxt[0] = gf_mul(gamma, lam[0]);
        for (int i = 1; i <= T; i++) begin
            lam_nxt[i] = gf_mul(gamma, lam[i]) ^ gf_mul(delta, bb[i-1]);
            if (upd) bb_nxt[i] = lam[i-1];
        end
        if (!upd) begin
            for (int i = 2; i <= T; i++) bb_nxt[i] = bb[i-2];
        end
    end

    // Degree is the index of the highest nonzero locator coefficient
    always_comb begin
        degree = '0;
        for (int i = 1; i <= T; i++) begin
            if (lam[i] != '0) degree = DW'(i);
        end
    end

`ifdef BCH_IBM_NORMALIZE_EN
    logic [M-1:0]  acc;
    logic [M-1:0]  pw;
    logic [NW-1:0] ncnt;
    logic [M-1:0]  pw_sq;

    // Next power a^(2^(n+1)) for the square-and-multiply inversion chain
    always_comb pw_sq = gf_mul(pw, pw);
`endif

    // Control FSM with registered handshakes; iterations update Lambda, B, gamma and k each edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            syn       <= '0;
            lam       <= '0;
            bb        <= '0;
            gamma     <= '0;
            k         <= '0;
            r         <= '0;
`ifdef BCH_IBM_NORMALIZE_EN
            acc       <= '0;
            pw        <= '0;
            ncnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        syn      <= syndromes;
                        lam      <= '0;
                        lam[0]   <= M'(1);
                        bb       <= '0;
                        bb[0]    <= M'(1);
                        gamma    <= M'(1);
                        k        <= '0;
                        r        <= '0;
                        in_ready <= 1'b0;
                        state    <= ITER;
                    end
                end
                ITER: begin
                    lam <= lam_nxt;
                    bb  <= bb_nxt;
                    if (upd) begin
                        gamma <= delta;
                        k     <= ~k;
                    end else begin
                        k     <= k + K_ONE;
                    end
                    r <= r + RW'(1);
                    if (r == RW'(T - 1)) begin
`ifdef BCH_IBM_NORMALIZE_EN
                        // Lambda0 is fixed from here on; start the inversion from its new value
                        acc   <= M'(1);
                        pw    <= lam_nxt[0];
                        ncnt  <= '0;
                        state <= NORM;
`else
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef BCH_IBM_NORMALIZE_EN
                NORM: begin
                    if (ncnt != NW'(M - 1)) begin
                        acc  <= gf_mul(acc, pw_sq);
                        pw   <= pw_sq;
                        ncnt <= ncnt + NW'(1);
                    end else begin
                        for (int i = 0; i <= T; i++) lam[i] <= gf_mul(lam[i], acc);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_ibm_solver.sv
// Directed bench for bch_ibm_solver at M=4, T=2 over GF(16) with x^4+x+1.
// Latency: checks result arrival T (or T+M with normalisation) cycles after accept.
// Backpressure: holds out_ready low in DONE while toggling in_valid to confirm no capture.
module tb_bch_ibm_solver;

    localparam int M = 4;
    localparam int T = 2;
`ifdef BCH_IBM_NORMALIZE_EN
    localparam int          LAT   = T + M;
    localparam logic [11:0] LAM_A = 12'h3B1;
`else
    localparam int          LAT   = T;
    localparam logic [11:0] LAM_A = 12'hE9B;
`endif
    localparam logic [15:0] SYN_A = 16'hD29B;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] syndromes;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] lambda;
    logic [1:0]  degree;

    int n_checks = 0;
    int n_pass   = 0;

    bch_ibm_solver #(.M(M), .T(T), .PRIM_POLY(5'b10011)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .syndromes (syndromes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lambda    (lambda),
        .degree    (degree)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called #1 after a rising edge with the solver idle; returns with the result held in DONE
    task automatic run_vec(input string tag, input logic [15:0] syn, input logic [11:0] exp_lam,
                           input logic [1:0] exp_deg);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        syndromes = syn;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_lambda"}, 32'(lambda), 32'(exp_lam));
        check({tag, "_degree"}, 32'(degree), 32'(exp_deg));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        syndromes = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_lambda", 32'(lambda), 32'd0);
        check("rst_degree", 32'(degree), 32'd0);

        // Two-error pattern
        run_vec("vecA", SYN_A, LAM_A, 2'd2);
        release_out("vecA");

        // Single error at position 0: Lambda = 1 + x
        run_vec("single", 16'h1111, 12'h011, 2'd1);
        release_out("single");

        // No errors: Lambda = 1
        run_vec("zero", 16'h0000, 12'h001, 2'd0);
        release_out("zero");

        // Stall in DONE with in_valid toggling and new syndromes offered
        run_vec("stall", SYN_A, LAM_A, 2'd2);
        for (int c = 0; c < 5; c++) begin
            in_valid  = ~in_valid;
            syndromes = 16'h1111;
            @(posedge clk);
            #1;
            check("stall_lambda", 32'(lambda), 32'(LAM_A));
            check("stall_degree", 32'(degree), 32'd2);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_out("stall");
        @(posedge clk);
        #1;
        check("stall_no_capture", 32'(in_ready), 32'd1);

        // Abort during the second iteration
        in_valid  = 1'b1;
        syndromes = SYN_A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_lambda", 32'(lambda), 32'd0);
        check("abort_degree", 32'(degree), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec("after_abort", SYN_A, LAM_A, 2'd2);
        release_out("after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
